// File: rtl/serial_compare_ctrl_pkg.sv
// Shared constants for the serial comparator: state encodings and default operand width.
// Imported by the RTL and by the testbench so both agree on encodings.
package serial_compare_ctrl_pkg;

    localparam int unsigned DefaultW = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompare = 2'd1,
        StDone    = 2'd2
    } state_e;

endpackage

// File: rtl/serial_compare_ctrl_bitcmp.sv
// 1-bit magnitude comparator: k = (a <= b), l = (a >= b).
// Both high means equal; exactly one high gives the ordering.
module serial_compare_ctrl_bitcmp (
    input  logic a,
    input  logic b,
    output logic k,
    output logic l
);

    assign k = ~a | b;
    assign l = a | ~b;

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial MSB-first unsigned comparator: captures A/B on START, examines one bit per cycle
// and reports GT/EQ/LT with a one-cycle DONE pulse.
module serial_compare_ctrl
    import serial_compare_ctrl_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         BUSY,
    output logic         DONE,
    output logic         GT,
    output logic         EQ,
    output logic         LT
);

    localparam int unsigned IdxW = $clog2(W);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            gt_q, gt_d;
    logic            eq_q, eq_d;
    logic            lt_q, lt_d;
    logic            bit_k;
    logic            bit_l;

    serial_compare_ctrl_bitcmp u_bitcmp (
        .a (a_q[W-1]),
        .b (b_q[W-1]),
        .k (bit_k),
        .l (bit_l)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;

        case (state_q)
            StIdle: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    idx_d   = IdxW'(W - 1);
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                if (bit_k && bit_l) begin
                    // Equal bit: index 0 terminates, otherwise move to the next lower bit.
                    if (idx_q == '0) begin
                        eq_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q - IdxW'(1);
                        a_d   = {a_q[W-2:0], 1'b0};
                        b_d   = {b_q[W-2:0], 1'b0};
                    end
                end else begin
                    gt_d    = bit_l;
                    lt_d    = bit_k;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign BUSY = (state_q != StIdle);
    assign DONE = (state_q == StDone);
    assign GT   = gt_q;
    assign EQ   = eq_q;
    assign LT   = lt_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed self-checking bench for serial_compare_ctrl at the default width.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_compare_ctrl;
    import serial_compare_ctrl_pkg::*;

    localparam int unsigned TW = DefaultW;

    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          gt;
        logic          eq;
        logic          lt;
        int unsigned   edges;
        logic          hold;
    } vec_t;

    logic          CLK;
    logic          RST_N;
    logic          START;
    logic [TW-1:0] A;
    logic [TW-1:0] B;
    logic          BUSY;
    logic          DONE;
    logic          GT;
    logic          EQ;
    logic          LT;

    int checks = 0;
    int errors = 0;

    vec_t vecs[9];

    serial_compare_ctrl #(
        .W (TW)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .GT    (GT),
        .EQ    (EQ),
        .LT    (LT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts at a falling edge; with hold set, START stays high and A/B are swapped after capture.
    task automatic run_cmp(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic gt,
                           input logic eq, input logic lt, input int unsigned edges,
                           input logic hold);
        int unsigned n;
        A     = a;
        B     = b;
        START = 1'b1;
        @(negedge CLK);
        check("cap_busy", {31'd0, BUSY}, 32'd1);
        check("cap_done", {31'd0, DONE}, 32'd0);
        check("cap_flags", {29'd0, GT, EQ, LT}, 32'd0);
        if (hold) begin
            A = b;
            B = a;
        end else begin
            START = 1'b0;
        end
        n = 0;
        while (!DONE && n < TW + 4) begin
            @(negedge CLK);
            n++;
        end
        check("done_edges", n, edges);
        check("res_flags", {29'd0, GT, EQ, LT}, {29'd0, gt, eq, lt});
        check("done_busy", {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        check("done_pulse", {31'd0, DONE}, 32'd0);
        check("idle_busy", {31'd0, BUSY}, 32'd0);
        START = 1'b0;
        @(negedge CLK);
        check("no_restart", {31'd0, BUSY}, 32'd0);
        check("hold_flags", {29'd0, GT, EQ, LT}, {29'd0, gt, eq, lt});
    endtask

    initial begin
        int seen;

        vecs[0] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1, 1'b0};
        vecs[1] = '{8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 8, 1'b0};
        vecs[2] = '{8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 8, 1'b0};
        vecs[3] = '{8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 1, 1'b1};
        vecs[4] = '{8'h40, 8'h60, 1'b0, 1'b0, 1'b1, 3, 1'b1};
        vecs[5] = '{8'h0C, 8'h08, 1'b1, 1'b0, 1'b0, 6, 1'b0};
        vecs[6] = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8, 1'b0};
        vecs[7] = '{8'h7F, 8'h80, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[8] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8, 1'b1};

        RST_N = 1'b1;
        START = 1'b0;
        A     = '0;
        B     = '0;
        #2 RST_N = 1'b0;

        // START during reset must be ignored.
        @(negedge CLK);
        START = 1'b1;
        A     = 8'h80;
        B     = 8'h7F;
        @(negedge CLK);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_flags", {29'd0, GT, EQ, LT}, 32'd0);

        // Release and start on the very first rising edge.
        RST_N = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].gt, vecs[i].eq, vecs[i].lt, vecs[i].edges,
                    vecs[i].hold);
        end

        // Result hold then back-to-back start.
        run_cmp(8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("idle_lt_hold", {29'd0, GT, EQ, LT}, 32'd1);
        end
        run_cmp(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0);

        // Reset abort mid-comparison.
        A     = 8'h01;
        B     = 8'h02;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        check("abort_pre_busy", {31'd0, BUSY}, 32'd1);
        RST_N = 1'b0;
        #1;
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_done", {31'd0, DONE}, 32'd0);
        check("abort_flags", {29'd0, GT, EQ, LT}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (DONE || BUSY || GT || EQ || LT) seen++;
        end
        check("abort_quiet", seen, 0);

        // Reset clears a held result immediately.
        run_cmp(8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 8, 1'b0);
        RST_N = 1'b0;
        #1;
        check("rst_clear_flags", {29'd0, GT, EQ, LT}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_compare_ctrl.md
SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits, legal range 2..32.
REQ-002 SHALL have port CLK, input, 1 bit: the only clock, rising-edge active.
REQ-003 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port START, input, 1 bit: request a comparison of A and B.
REQ-005 SHALL have port A, input, W bits: operand A, unsigned.
REQ-006 SHALL have port B, input, W bits: operand B, unsigned.
REQ-007 SHALL have port BUSY, output, 1 bit: high whenever the controller is not in IDLE.
REQ-008 SHALL have port DONE, output, 1 bit: one-cycle pulse marking that a new result is valid.
REQ-009 SHALL have ports GT, EQ, LT, each output, 1 bit: registered result flags, one-hot when valid.

Function
REQ-010 SHALL compare A and B bit-serially, MSB first, using exactly one 1-bit comparator per cycle:
- per-bit outputs K = (a<=b) and L = (a>=b);
- K&L means equal, L only means greater, K only means less.
REQ-011 SHALL implement states IDLE, COMPARE and DONE.
REQ-012 SHALL capture A and B into internal shift registers in IDLE when START=1 at a clock edge, then:
- load bit index to W-1;
- clear GT/EQ/LT to 0;
- go to COMPARE.
REQ-013 SHALL ignore START in COMPARE and DONE; changes on A or B after capture SHALL not affect the result.
REQ-014 SHALL, in COMPARE, go to DONE on the first unequal bit, with GT=1 (L only) or LT=1 (K only).
REQ-015 SHALL, when bit 0 is equal, go to DONE with EQ=1; otherwise it SHALL decrement the index and stay in COMPARE.
REQ-016 SHALL time the result as follows: if k bits are examined (1<=k<=W), DONE is high for exactly the one cycle following the k-th clock edge after the edge that sampled START.
REQ-017 SHALL have DONE return to IDLE unconditionally after one cycle; a START seen in the DONE cycle is dropped.
REQ-018 SHALL hold GT/EQ/LT stable from DONE until the next accepted START.
REQ-019 SHALL never assert more than one of GT/EQ/LT.
REQ-020 SHALL size the index counter to $clog2(W) bits with no wrap-around; index 0 always terminates.

Reset
REQ-021 SHALL, while RST_N=0, immediately force:
- state IDLE;
- BUSY=0, DONE=0;
- GT=EQ=LT=0;
- shift registers and index cleared.
REQ-022 SHALL abort a comparison on reset mid-operation, with no DONE pulse and no partial result after release.
REQ-023 SHALL accept START on the first rising CLK edge after RST_N deasserts.

Structure
REQ-024 SHALL take the state encodings (IDLE=2'd0, COMPARE=2'd1, DONE=2'd2) and the default W from a shared include file of constants used by both the RTL and the bench.
REQ-025 SHALL instantiate exactly one sub-module, the team's existing 1-bit COMPARATOR block, fed by the current MSB of each shift register.
REQ-026 SHALL contain all sequencing logic (FSM, index, shifting, result latching) in serial_compare_ctrl, with a target of 120-250 lines.

Verification (W=8)
REQ-027 SHALL pass early exit: A=0x80, B=0x7F, START one cycle -> DONE 1 edge later, GT=1, EQ=LT=0, BUSY high for 2 cycles.
REQ-028 SHALL pass full length: A=0xA5, B=0xA5 -> DONE 8 edges after START, EQ=1. A=0x12, B=0x13 -> DONE at 8 edges, LT=1.
REQ-029 SHALL pass ignored START: START held high and A/B changed to 0x00 during COMPARE of A=0xF0, B=0x0F -> a single DONE, GT=1, no second comparison until after IDLE.
REQ-030 SHALL pass reset abort: RST_N pulsed low 3 cycles into A=0x01, B=0x02 -> all outputs 0 immediately, no DONE afterwards.
REQ-031 SHALL pass result hold and back-to-back: after LT result, 5 idle cycles keep LT=1; a new START with A=0xFF, B=0x00 clears LT on the capture edge and yields GT one edge later.
